// File: rtl/div_sequencer_pkg.sv
// div_pkg: shared types and RV32M decode constants for the divide sequencer.
//   div_state_t : sequencer FSM states IDLE -> CALC -> FIX -> DONE
//   F3_*        : funct3 encodings of DIV/DIVU/REM/REMU
//   OPC_RTYPE, F7_MULDIV : opcode/funct7 that select the M-extension ops
package div_pkg;
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;
    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;
    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;
endpackage

// File: rtl/div_sequencer_if.sv
// div_sequencer_if: request/response bundle between EX and the divide sequencer.
//   start, funct3, op_a, op_b, flush : request side (driven by master)
//   stall, busy, done, result        : status/response side (driven by slave)
interface div_sequencer_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    modport master (output start, funct3, op_a, op_b, flush, input stall, busy, done, result);
    modport slave  (input start, funct3, op_a, op_b, flush, output stall, busy, done, result);
endinterface

// File: rtl/div_sequencer_step.sv
// div_step: one combinational radix-2 restoring division step.
//   rem, quo, div : partial remainder, dividend/quotient shift register, divisor magnitude
//   rem_n, quo_n  : values after shifting in the next dividend bit and trial subtraction
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] div,
    output logic [XLEN-1:0] rem_n,
    output logic [XLEN-1:0] quo_n
);
    logic [XLEN:0]   sh;
    logic [XLEN-1:0] diff;
    logic            ge;
    assign sh    = {rem, quo[XLEN-1]};
    assign ge    = sh >= {1'b0, div};
    // when ge holds the difference fits in XLEN bits, so the carry-out can be dropped
    assign diff  = sh[XLEN-1:0] - div;
    assign rem_n = ge ? diff : sh[XLEN-1:0];
    assign quo_n = {quo[XLEN-2:0], ge};
endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle RV32M DIV/DIVU/REM/REMU sequencer (restoring, 1 bit/cycle).
//   clk, rst_n : core clock, asynchronous active-low reset
//   bus        : div_sequencer_if.slave (start/funct3/op_a/op_b/flush in,
//                stall/busy/done/result out)
// Optional build macro DIV_EARLY_EXIT_EN: divide-by-zero and |op_a|<|op_b| skip CALC.
module div_sequencer
    import div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    div_sequencer_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    div_state_t      state, state_n;
    logic [XLEN-1:0] rem_q, quo_q, div_q, result_q, rem_n, quo_n;
    logic [XLEN-1:0] abs_a, abs_b, fix_val;
    logic [CW-1:0]   cnt_q;
    logic            sign_a_q, sign_b_q, is_rem_q;
    logic            accept, is_signed, is_rem, sign_a, sign_b, early, neg_q, neg_r;
    assign is_signed = bus.funct3 == F3_DIV || bus.funct3 == F3_REM;
    assign is_rem    = bus.funct3 == F3_REM || bus.funct3 == F3_REMU;
    assign sign_a    = is_signed && bus.op_a[XLEN-1];
    assign sign_b    = is_signed && bus.op_b[XLEN-1];
    assign abs_a     = sign_a ? -bus.op_a : bus.op_a;
    assign abs_b     = sign_b ? -bus.op_b : bus.op_b;
    assign accept    = state == IDLE && bus.start && bus.funct3[2] && !bus.flush;
`ifdef DIV_EARLY_EXIT_EN
    assign early = bus.op_b == '0 || abs_a < abs_b;
`else
    assign early = 1'b0;
`endif
    // a zero divisor leaves the all-ones quotient un-negated so DIV x/0 is always -1
    assign neg_q   = (sign_a_q ^ sign_b_q) && div_q != '0;
    assign neg_r   = sign_a_q;
    assign fix_val = is_rem_q ? (neg_r ? -rem_q : rem_q) : (neg_q ? -quo_q : quo_q);
    div_step #(.XLEN(XLEN)) u_step (
        .rem  (rem_q),
        .quo  (quo_q),
        .div  (div_q),
        .rem_n(rem_n),
        .quo_n(quo_n)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end
    always_comb begin
        state_n = state;
        if (state == IDLE)       state_n = accept ? (early ? FIX : CALC) : IDLE;
        else if (bus.flush)      state_n = IDLE;
        else if (state == CALC)  state_n = cnt_q == '0 ? FIX : CALC;
        else                     state_n = state == FIX ? DONE : IDLE;
        bus.stall = accept || state == CALC || state == FIX;
        bus.busy  = state != IDLE;
        bus.done  = state == DONE && !bus.flush;
    end
    assign bus.result = result_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            is_rem_q <= 1'b0;
        end else begin
            if (accept) begin
                sign_a_q <= sign_a;
                sign_b_q <= sign_b;
                is_rem_q <= is_rem;
                div_q    <= abs_b;
                cnt_q    <= CW'(XLEN - 1);
                // early exit presets the final quotient/remainder; otherwise the dividend shifts through quo
                rem_q    <= early ? abs_a : '0;
                quo_q    <= early ? {XLEN{bus.op_b == '0}} : abs_a;
            end else if (state == CALC && !bus.flush) begin
                rem_q <= rem_n;
                quo_q <= quo_n;
                cnt_q <= cnt_q - 1'b1;
            end
            if (state == FIX && !bus.flush) result_q <= fix_val;
        end
    end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed self-checking bench for div_sequencer with a schedule/arithmetic model.
module tb_div_sequencer;
    import div_pkg::*;
    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 2;
`ifdef DIV_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        e;
    } vec_t;
    localparam int NV = 18;
    localparam vec_t VECS [NV] = '{
        '{F3_DIV,  32'd100,        32'd7,          32'd14,         1'b0},
        '{F3_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0},
        '{F3_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0},
        '{F3_REMU, 32'hFFFF_FFF9,  32'd2,          32'd1,          1'b0},
        '{F3_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1},
        '{F3_REMU, 32'd5,          32'd0,          32'd5,          1'b1},
        '{F3_DIV,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  1'b1},
        '{F3_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1'b1},
        '{F3_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0},
        '{F3_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0},
        '{F3_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0},
        '{F3_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0},
        '{F3_DIV,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          1'b0},
        '{F3_REM,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'hFFFF_FFFF,  1'b0},
        '{F3_DIVU, 32'd3,          32'd10,         32'd0,          1'b1},
        '{F3_REM,  32'd3,          32'hFFFF_FFF6,  32'd3,          1'b1},
        '{F3_DIV,  32'hFFFF_FFFD,  32'd10,         32'd0,          1'b1},
        '{F3_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0}
    };
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   acc_c, done_c, busy_last, stall_last;
    bit   done_en, res_upd;
    logic [31:0] exp_res, last_res;
    div_sequencer_if #(.XLEN(XLEN)) bus ();
    div_sequencer #(.XLEN(XLEN)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask
    function automatic logic [31:0] mag(input logic [2:0] f3, input logic [31:0] v);
        return ((f3 == F3_DIV || f3 == F3_REM) && v[31]) ? -v : v;
    endfunction
    // RISC-V M-extension semantics straight from the ISA rules
    function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        case (f3)
            F3_DIVU: return b == 0 ? 32'hFFFF_FFFF : a / b;
            F3_REMU: return b == 0 ? a : a % b;
            F3_DIV:  return b == 0 ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            default: return b == 0 ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
        endcase
    endfunction
    function automatic int lat_of(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return (EARLY && (b == 0 || mag(f3, a) < mag(f3, b))) ? 2 : LAT;
    endfunction
    function automatic bit m_idle();
        return !(cyc > acc_c && cyc <= busy_last);
    endfunction
    function automatic logic [31:0] cur_res();
        return (res_upd && cyc >= done_c) ? exp_res : last_res;
    endfunction
    task automatic m_reset();
        acc_c = 32'h7FFF_FFFF;
        done_c = -1;
        busy_last = -1;
        stall_last = -1;
        done_en = 1'b0;
        res_upd = 1'b0;
        exp_res = '0;
        last_res = '0;
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic apply(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.funct3 = f3;
        bus.op_a = a;
        bus.op_b = b;
        if (rst_n && m_idle() && f3[2] && !bus.flush) begin
            last_res = cur_res();
            acc_c = cyc;
            done_c = cyc + lat_of(f3, a, b);
            busy_last = done_c;
            stall_last = done_c - 1;
            done_en = 1'b1;
            res_upd = 1'b1;
            exp_res = ref_div(f3, a, b);
        end
    endtask
    task automatic do_flush();
        bus.flush = 1'b1;
        if (!m_idle()) begin
            busy_last = cyc;
            if (stall_last > cyc) stall_last = cyc;
            done_en = 1'b0;
            if (cyc < done_c) res_upd = 1'b0;
        end
        step();
        bus.flush = 1'b0;
    endtask
    task automatic wait_done(input string name, input int n0, input int lat, input logic [31:0] lit);
        int got;
        got = -1;
        for (int i = 0; i < LAT + 20 && got < 0; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) got = cyc;
        end
        chk({name, "_latency"}, 32'(got - n0), 32'(lat));
        chk({name, "_result"}, bus.result, lit);
        chk({name, "_stall_at_done"}, {31'b0, bus.stall}, 32'd0);
        step();
    endtask
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] lit, input bit e);
        int n0;
        n0 = cyc;
        chk({name, "_model"}, ref_div(f3, a, b), lit);
        apply(f3, a, b);
        @(negedge clk);
        chk({name, "_stall_at_accept"}, {31'b0, bus.stall}, 32'd1);
        step();
        bus.start = 1'b0;
        wait_done(name, n0, (EARLY && e) ? 2 : LAT, lit);
    endtask
    // per-cycle comparison of every output against the model's schedule
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_stall", {31'b0, bus.stall}, 32'd0);
            chk("rst_busy", {31'b0, bus.busy}, 32'd0);
            chk("rst_done", {31'b0, bus.done}, 32'd0);
            chk("rst_result", bus.result, 32'd0);
        end else begin
            chk("stall", {31'b0, bus.stall}, {31'b0, cyc >= acc_c && cyc <= stall_last});
            chk("busy", {31'b0, bus.busy}, {31'b0, cyc > acc_c && cyc <= busy_last});
            chk("done", {31'b0, bus.done}, {31'b0, done_en && cyc == done_c});
            chk("result", bus.result, cur_res());
        end
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog expired");
    end
    initial begin
        int n0;
        bus.start = 1'b0;
        bus.funct3 = '0;
        bus.op_a = '0;
        bus.op_b = '0;
        bus.flush = 1'b0;
        m_reset();
        repeat (3) step();
        @(negedge clk);
        chk("reset_result", bus.result, 32'd0);
        chk("reset_busy", {31'b0, bus.busy}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < NV; i++)
            run_op($sformatf("vec%0d", i), VECS[i].f3, VECS[i].a, VECS[i].b, VECS[i].r, VECS[i].e);
        n0 = cyc;
        apply(F3_DIVU, 32'd100, 32'd3);
        step();
        bus.start = 1'b0;
        while (cyc < n0 + 10) step();
        do_flush();
        @(negedge clk);
        chk("flush_busy", {31'b0, bus.busy}, 32'd0);
        chk("flush_result_kept", bus.result, 32'hFFFF_FFFF);
        step();
        run_op("divu_9_3_after_flush", F3_DIVU, 32'd9, 32'd3, 32'd3, 1'b0);
        n0 = cyc;
        apply(F3_DIVU, 32'd50, 32'd5);
        step();
        bus.start = 1'b0;
        step();
        step();
        apply(F3_DIV, 32'd1, 32'd1);
        step();
        bus.start = 1'b0;
        wait_done("start_while_busy", n0, LAT, 32'd10);
        apply(3'b001, 32'd4, 32'd2);
        @(negedge clk);
        chk("f3_001_stall", {31'b0, bus.stall}, 32'd0);
        step();
        bus.start = 1'b0;
        @(negedge clk);
        chk("f3_001_busy", {31'b0, bus.busy}, 32'd0);
        step();
        bus.flush = 1'b1;
        apply(F3_DIVU, 32'd8, 32'd2);
        @(negedge clk);
        chk("flush_start_stall", {31'b0, bus.stall}, 32'd0);
        step();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_start_busy", {31'b0, bus.busy}, 32'd0);
        step();
        n0 = cyc;
        apply(F3_DIVU, 32'd20, 32'd4);
        step();
        bus.start = 1'b0;
        while (cyc < n0 + LAT) step();
        do_flush();
        @(negedge clk);
        chk("flush_in_done_result", bus.result, 32'd5);
        step();
        n0 = cyc;
        apply(F3_DIV, 32'd1000, 32'd7);
        step();
        bus.start = 1'b0;
        while (cyc < n0 + 5) step();
        rst_n = 1'b0;
        m_reset();
        @(negedge clk);
        chk("rst_mid_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_mid_result", bus.result, 32'd0);
        step();
        rst_n = 1'b1;
        repeat (LAT + 4) step();
        run_op("div_100_7_after_reset", F3_DIV, 32'd100, 32'd7, 32'd14, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
